// File: rtl/mux3_port_arb.sv
// Round-robin arbiter/sequencer for one shared port behind a one-hot 3:1 mux.
// Optional abort on stuck transactions: define ARB_TIMEOUT_EN.
module mux3_port_arb #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] req,
    output logic [2:0] sel,
    output logic       bus_req,
    input  logic       bus_addr_ok,
    input  logic       bus_data_ok,
    output logic [2:0] done,
    output logic [2:0] err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] last_q, last_d;
    logic [2:0] done_q, done_d;
    logic       bus_req_q, bus_req_d;
    logic       busy_q, busy_d;
    logic [2:0] grant;
    logic       complete;
    logic       finish;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       err_q, err_d;
    logic             tmo;

    assign tmo = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_params;
    assign unused_params = ^{TIMEOUT_CYC, CNT_W};
`endif

    // Scan starts at the bit after the last winner, wrapping around.
    always_comb begin
        grant = '0;
        case (last_q)
            3'b001: begin
                if (req[1])      grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            3'b010: begin
                if (req[2])      grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end

    assign complete = ((state_q == ADDR) && bus_addr_ok && bus_data_ok) ||
                      ((state_q == DATA) && bus_data_ok);
`ifdef ARB_TIMEOUT_EN
    assign finish = complete || tmo;
`else
    assign finish = complete;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        bus_req_d = bus_req_q;
        busy_d    = busy_q;
        done_d    = '0;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = '0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d   = ADDR;
                    sel_d     = grant;
                    bus_req_d = 1'b1;
                    busy_d    = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    state_d   = DATA;
                    bus_req_d = 1'b0;
                end
            end
            DATA: ;
            default: state_d = IDLE;
        endcase

        // A completion on the timeout cycle takes precedence over the abort.
        if (state_q != IDLE) begin
`ifdef ARB_TIMEOUT_EN
            cnt_d = cnt_q + CNT_W'(1);
`endif
            if (finish) begin
                state_d   = IDLE;
                sel_d     = '0;
                bus_req_d = 1'b0;
                busy_d    = 1'b0;
                last_d    = sel_q;
                done_d    = complete ? sel_q : 3'b000;
`ifdef ARB_TIMEOUT_EN
                err_d     = complete ? 3'b000 : sel_q;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            last_q    <= 3'b100;
            done_q    <= '0;
            bus_req_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            done_q    <= done_d;
            bus_req_q <= bus_req_d;
            busy_q    <= busy_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign sel     = sel_q;
    assign bus_req = bus_req_q;
    assign done    = done_q;
    assign busy    = busy_q;
`ifdef ARB_TIMEOUT_EN
    assign err     = err_q;
`else
    assign err     = 3'b000;
`endif

endmodule

// File: tb/tb_mux3_port_arb.sv
// Scoreboard bench for mux3_port_arb: stimulus queues expected grants and
// done/err events, a negedge monitor pops and compares them.
module tb_mux3_port_arb;

    logic       clk;
    logic       resetn;
    logic [2:0] req;
    logic [2:0] sel;
    logic       bus_req;
    logic       bus_addr_ok;
    logic       bus_data_ok;
    logic [2:0] done;
    logic [2:0] err;
    logic       busy;

    mux3_port_arb #(
        .TIMEOUT_CYC(8),
        .CNT_W      (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .sel        (sel),
        .bus_req    (bus_req),
        .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok),
        .done       (done),
        .err        (err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    logic [5:0]  evt_q[$];    // {done, err}
    logic [2:0]  grant_q[$];
    logic        mon_en = 1'b0;
    logic [2:0]  sel_prev = 3'b000;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] outs();
        return 16'({sel, bus_req, busy, done, err});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("onehot", 16'({$onehot0(sel), $onehot0(done), $onehot0(err)}), 16'h7);
            if (done != 3'b000 || err != 3'b000) begin
                if (evt_q.size() == 0) chk("unexpected_done_err", 16'({done, err}), 16'h0);
                else chk("done_err", 16'({done, err}), 16'(evt_q.pop_front()));
            end
            if (sel != 3'b000 && sel_prev == 3'b000) begin
                if (grant_q.size() == 0) chk("unexpected_grant", 16'(sel), 16'h0);
                else chk("grant", 16'(sel), 16'(grant_q.pop_front()));
            end
            sel_prev = sel;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; req = 3'b000; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        tick(); tick();
        chk("reset_outs", outs(), 16'h0);
        resetn = 1'b1;
        mon_en = 1'b1;

        // Single request with split address/data phases
        req = 3'b010; grant_q.push_back(3'b010);
        tick();
        chk("t1_addr", 16'({sel, bus_req, busy}), 16'({3'b010, 1'b1, 1'b1}));
        tick();
        chk("t1_addr_hold", 16'({sel, bus_req}), 16'({3'b010, 1'b1}));
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        chk("t1_data", 16'({sel, bus_req, busy}), 16'({3'b010, 1'b0, 1'b1}));
        tick();
        bus_data_ok = 1'b1; evt_q.push_back({3'b010, 3'b000});
        tick();
        bus_data_ok = 1'b0; req = 3'b000;
        chk("t1_done", 16'({done, sel, busy}), 16'({3'b010, 3'b000, 1'b0}));
        tick();
        chk("t1_done_one_cycle", 16'(done), 16'h0);

        // Round robin with combined handshake, starting fresh from reset
        resetn = 1'b0; tick(); resetn = 1'b1;
        req = 3'b111; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
        grant_q.push_back(3'b001); grant_q.push_back(3'b010);
        grant_q.push_back(3'b100); grant_q.push_back(3'b001);
        evt_q.push_back({3'b001, 3'b000}); evt_q.push_back({3'b010, 3'b000});
        evt_q.push_back({3'b100, 3'b000}); evt_q.push_back({3'b001, 3'b000});
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_addr", 16'({bus_req, busy}), 16'h3);
            tick();
            chk("rr_idle", 16'({bus_req, busy, sel}), 16'h0);
        end
        req = 3'b000; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        tick();
        chk("rr_quiet", outs(), 16'h0);

        // Grant lock: requester drops, another raises while in DATA
        req = 3'b001; grant_q.push_back(3'b001);
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0; req = 3'b100;
        tick();
        chk("lock_sel0", 16'(sel), 16'h1);
        tick();
        chk("lock_sel1", 16'(sel), 16'h1);
        bus_data_ok = 1'b1;
        evt_q.push_back({3'b001, 3'b000}); grant_q.push_back(3'b100);
        tick();
        bus_data_ok = 1'b0;
        tick();
        chk("lock_next", 16'(sel), 16'h4);
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; evt_q.push_back({3'b100, 3'b000});
        tick();
        req = 3'b000; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        tick();

        // data_ok before addr_ok in ADDR is ignored
        req = 3'b010; grant_q.push_back(3'b010);
        tick();
        bus_data_ok = 1'b1;
        tick();
        chk("early_data", 16'({bus_req, busy, done}), 16'({1'b1, 1'b1, 3'b000}));
        bus_data_ok = 1'b0; bus_addr_ok = 1'b1;
        tick();
        chk("early_data_addr", 16'({bus_req, busy}), 16'h1);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; evt_q.push_back({3'b010, 3'b000});
        tick();
        req = 3'b000; bus_data_ok = 1'b0;
        tick();

        // Handshake strobes in IDLE are ignored
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
        tick();
        chk("idle_ignore", outs(), 16'h0);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;

        // Reset in DATA aborts silently; late data_ok is ignored
        req = 3'b010; grant_q.push_back(3'b010);
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        chk("midrst_pre", 16'({sel, busy}), 16'({3'b010, 1'b1}));
        resetn = 1'b0;
        tick();
        chk("midrst_outs", outs(), 16'h0);
        resetn = 1'b1; req = 3'b000; bus_data_ok = 1'b1;
        tick();
        bus_data_ok = 1'b0;
        tick();
        chk("midrst_late", outs(), 16'h0);

`ifdef ARB_TIMEOUT_EN
        // Abort 8 cycles after ADDR entry
        req = 3'b100; grant_q.push_back(3'b100);
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        for (int c = 2; c < 8; c++) begin
            tick();
            chk("tmo_wait", 16'({busy, err}), 16'h8);
        end
        evt_q.push_back({3'b000, 3'b100});
        tick();
        chk("tmo_err", outs(), 16'({3'b000, 1'b0, 1'b0, 3'b000, 3'b100}));
        req = 3'b000;
        tick();
        chk("tmo_err_one_cycle", outs(), 16'h0);

        // Completion on the timeout cycle wins
        req = 3'b100; grant_q.push_back(3'b100);
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        for (int c = 2; c < 8; c++) tick();
        bus_data_ok = 1'b1; evt_q.push_back({3'b100, 3'b000});
        tick();
        chk("tmo_race", outs(), 16'({3'b000, 1'b0, 1'b0, 3'b100, 3'b000}));
        bus_data_ok = 1'b0; req = 3'b000;
        tick();
`else
        // Without the timeout, a transaction waits indefinitely
        req = 3'b001; grant_q.push_back(3'b001);
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        chk("wait_long", 16'({sel, bus_req, busy, err}), 16'({3'b001, 1'b0, 1'b1, 3'b000}));
        bus_data_ok = 1'b1; evt_q.push_back({3'b001, 3'b000});
        tick();
        chk("wait_done", outs(), 16'({3'b000, 1'b0, 1'b0, 3'b001, 3'b000}));
        bus_data_ok = 1'b0; req = 3'b000;
        tick();
`endif

        tick(); tick();
        chk("evt_q_drained", 16'(evt_q.size()), 16'h0);
        chk("grant_q_drained", 16'(grant_q.size()), 16'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
